// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the frame assembler state type.
package eth_pkg;

  localparam int unsigned FRAME_BYTES    = 1500;
  localparam int unsigned ETH_HDR_BYTES  = 14;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StHold,
    StDrop
  } asm_state_t;

endpackage

// File: rtl/eth_frame_assembler.sv
// Ethernet frame assembler: collects a byte stream into a wide MSB-first frame
// buffer and holds it until the downstream parser takes it. Runt, errored and
// oversized frames are discarded.
// Optional feature: define ETH_ASM_DROP_CNT_EN to add a saturating drop_cnt output.
module eth_frame_assembler
  import eth_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = FRAME_BYTES * 8,
  parameter int unsigned MIN_BYTES   = ETH_HDR_BYTES
) (
  input  logic                   main_clk,
  input  logic                   main_rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_last,
  input  logic                   rx_error,
  output logic                   rx_ready,
  output logic [FRAME_WIDTH-1:0] eth_frame,
  output logic [10:0]            frame_len,
  output logic                   frame_valid,
`ifdef ETH_ASM_DROP_CNT_EN
  output logic [15:0]            drop_cnt,
`endif
  input  logic                   frame_ready
);

  localparam int unsigned IDX_W   = $clog2(FRAME_WIDTH);
  localparam logic [10:0] MAX_CNT = 11'(FRAME_WIDTH / 8);
  localparam logic [10:0] MIN_CNT = 11'(MIN_BYTES);

  asm_state_t       state_q;
  logic [10:0]      count_q;
  logic             err_q;

  logic             accept;
  logic             in_frame;
  logic             overflow;
  logic             frame_bad;
  logic [10:0]      slot;
  logic [10:0]      new_cnt;
  logic [IDX_W-1:0] bit_hi;

  // Decode the current byte: where it lands and whether it ends a bad frame.
  always_comb begin
    accept    = rx_valid & rx_ready;
    in_frame  = accept & ((state_q == StIdle) | (state_q == StRecv));
    slot      = (state_q == StIdle) ? 11'd0 : count_q;
    new_cnt   = slot + 11'd1;
    // Buffer already full: this byte has nowhere to go.
    overflow  = in_frame & (state_q == StRecv) & (count_q == MAX_CNT);
    frame_bad = err_q | rx_error | (new_cnt < MIN_CNT);
    bit_hi    = IDX_W'(FRAME_WIDTH - 1 - 8 * 32'(slot));
  end

  // Assembler FSM with registered handshake and frame outputs.
  always_ff @(posedge main_clk or negedge main_rst) begin
    if (!main_rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      err_q       <= 1'b0;
      eth_frame   <= '0;
      frame_len   <= '0;
      frame_valid <= 1'b0;
      rx_ready    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StRecv: begin
          rx_ready <= 1'b1;
          if (in_frame) begin
            if (overflow) begin
              if (rx_last) begin
                // Oversized frame ends on the overflowing byte: discard now.
                eth_frame <= '0;
                count_q   <= '0;
                err_q     <= 1'b0;
                state_q   <= StIdle;
              end else begin
                err_q   <= err_q | rx_error;
                state_q <= StDrop;
              end
            end else if (rx_last) begin
              if (frame_bad) begin
                eth_frame <= '0;
                count_q   <= '0;
                err_q     <= 1'b0;
                state_q   <= StIdle;
              end else begin
                eth_frame[bit_hi -: 8] <= rx_data;
                count_q     <= new_cnt;
                frame_len   <= new_cnt;
                frame_valid <= 1'b1;
                rx_ready    <= 1'b0;
                state_q     <= StHold;
              end
            end else begin
              eth_frame[bit_hi -: 8] <= rx_data;
              count_q <= new_cnt;
              err_q   <= err_q | rx_error;
              state_q <= StRecv;
            end
          end
        end
        StHold: begin
          if (frame_ready) begin
            eth_frame   <= '0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            rx_ready    <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StDrop: begin
          rx_ready <= 1'b1;
          if (accept) begin
            if (rx_last) begin
              eth_frame <= '0;
              count_q   <= '0;
              err_q     <= 1'b0;
              state_q   <= StIdle;
            end else begin
              err_q <= err_q | rx_error;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef ETH_ASM_DROP_CNT_EN
  logic drop_evt;

  // One event per discarded frame: overflow is counted when it is detected,
  // so the tail consumed in StDrop is not counted again.
  always_comb begin
    drop_evt = in_frame & (overflow | (rx_last & frame_bad));
  end

  // Saturating count of discarded frames.
  always_ff @(posedge main_clk or negedge main_rst) begin
    if (!main_rst) begin
      drop_cnt <= '0;
    end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
